generic_fifo_ctrl_sync: RTL and testbench



---
 rtl/generic_fifo_ctrl_sync.sv | 79 +++++++
 tb/tb_generic_fifo_ctrl_sync.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/generic_fifo_ctrl_sync.sv
// rtl/generic_fifo_ctrl_sync.sv - single-clock FIFO controller for a dual-port registered-read memory
// Optional sticky overflow/underflow flags are enabled by defining GENERIC_FIFO_ERR_FLAGS_EN.
module generic_fifo_ctrl_sync #(
    parameter int AWIDTH    = 3,
    parameter int AF_THRESH = 6,
    parameter int AE_THRESH = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wen,
    input  logic              ren,
`ifdef GENERIC_FIFO_ERR_FLAGS_EN
    input  logic              err_clr,
    output logic              overflow,
    output logic              underflow,
`endif
    output logic              mem_wen,
    output logic [AWIDTH-1:0] mem_waddr,
    output logic              mem_ren,
    output logic [AWIDTH-1:0] mem_raddr,
    output logic              rvalid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [AWIDTH:0]   count
);

    localparam logic [AWIDTH:0] AF_T = AF_THRESH[AWIDTH:0];
    localparam logic [AWIDTH:0] AE_T = AE_THRESH[AWIDTH:0];

    logic [AWIDTH:0] wptr;
    logic [AWIDTH:0] rptr;
    logic            wacc;
    logic            racc;

    // Flags depend only on registered pointers, so requests never ripple into them.
    assign empty        = (wptr == rptr);
    assign full         = (wptr[AWIDTH] != rptr[AWIDTH]) &&
                          (wptr[AWIDTH-1:0] == rptr[AWIDTH-1:0]);
    assign count        = wptr - rptr;
    assign almost_full  = (count >= AF_T);
    assign almost_empty = (count <= AE_T);

    assign wacc      = wen & ~full;
    assign racc      = ren & ~empty;
    assign mem_wen   = wacc;
    assign mem_ren   = racc;
    assign mem_waddr = wptr[AWIDTH-1:0];
    assign mem_raddr = rptr[AWIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr   <= '0;
            rptr   <= '0;
            rvalid <= 1'b0;
        end else begin
            if (wacc) wptr <= wptr + 1'b1;
            if (racc) rptr <= rptr + 1'b1;
            // Memory registers the read address, so data arrives one cycle after mem_ren.
            rvalid <= racc;
        end
    end

`ifdef GENERIC_FIFO_ERR_FLAGS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wen & full)    overflow <= 1'b1;
            else if (err_clr)  overflow <= 1'b0;
            if (ren & empty)   underflow <= 1'b1;
            else if (err_clr)  underflow <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_generic_fifo_ctrl_sync.sv
// tb/tb_generic_fifo_ctrl_sync.sv - scoreboard bench for generic_fifo_ctrl_sync with a registered-read memory model
module tb_generic_fifo_ctrl_sync;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wen = 1'b0;
    logic       ren = 1'b0;
    logic       mem_wen, mem_ren, rvalid, full, empty, almost_full, almost_empty;
    logic [2:0] mem_waddr, mem_raddr;
    logic [3:0] count;
`ifdef GENERIC_FIFO_ERR_FLAGS_EN
    logic       err_clr = 1'b0;
    logic       overflow, underflow;
`endif

    logic [7:0] wdata = 8'h00;
    logic [7:0] rdata;
    logic [7:0] mem [0:7];

    int n_pass  = 0;
    int n_total = 0;
    int exp_cnt = 0;
    logic [2:0] exp_wp = 3'd0;
    logic [2:0] exp_rp = 3'd0;

    logic [2:0] wa_q[$];
    logic [2:0] ra_q[$];
    logic [7:0] rd_q[$];
    logic [7:0] data_q[$];

    generic_fifo_ctrl_sync #(.AWIDTH(3), .AF_THRESH(6), .AE_THRESH(1)) dut (
        .clk(clk), .rst(rst), .wen(wen), .ren(ren),
`ifdef GENERIC_FIFO_ERR_FLAGS_EN
        .err_clr(err_clr), .overflow(overflow), .underflow(underflow),
`endif
        .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_ren(mem_ren), .mem_raddr(mem_raddr),
        .rvalid(rvalid), .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .count(count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wen) mem[mem_waddr] <= wdata;
        if (mem_ren) rdata <= mem[mem_raddr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: pops expectations whenever the DUT strobes a memory access or read data.
    always @(negedge clk) begin
        if (mem_wen) begin
            if (wa_q.size() == 0) chk("unexpected_mem_wen", 32'(mem_wen), 32'd0);
            else chk("mem_waddr", 32'(mem_waddr), 32'(wa_q.pop_front()));
        end
        if (mem_ren) begin
            if (ra_q.size() == 0) chk("unexpected_mem_ren", 32'(mem_ren), 32'd0);
            else chk("mem_raddr", 32'(mem_raddr), 32'(ra_q.pop_front()));
        end
        if (rvalid) begin
            if (rd_q.size() == 0) chk("unexpected_rvalid", 32'(rvalid), 32'd0);
            else chk("rdata", 32'(rdata), 32'(rd_q.pop_front()));
        end
    end

    task automatic step(input logic w, input logic r);
        logic wa, ra;
        wa = w && (exp_cnt != 8);
        ra = r && (exp_cnt != 0);
        wdata = 8'($urandom);
        if (ra) begin
            ra_q.push_back(exp_rp);
            rd_q.push_back(data_q.pop_front());
            exp_rp++;
            exp_cnt--;
        end
        if (wa) begin
            wa_q.push_back(exp_wp);
            data_q.push_back(wdata);
            exp_wp++;
            exp_cnt++;
        end
        wen = w;
        ren = r;
        @(posedge clk);
        #1;
        wen = 1'b0;
        ren = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wa_q.delete(); ra_q.delete(); rd_q.delete(); data_q.delete();
        exp_cnt = 0; exp_wp = 3'd0; exp_rp = 3'd0;
    endtask

    initial begin
        // 1: reset held three cycles
        repeat (3) @(posedge clk);
        #1;
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_almost_empty", 32'(almost_empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_almost_full", 32'(almost_full), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 2: fill, almost_full at 6, reject 9th write
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0);
            chk("fill_count", 32'(count), 32'(i + 1));
            chk("fill_almost_full", 32'(almost_full), (i + 1 >= 6) ? 32'd1 : 32'd0);
        end
        chk("fill_full", 32'(full), 32'd1);
        step(1'b1, 1'b0);
        chk("overfill_count", 32'(count), 32'd8);
        chk("overfill_full", 32'(full), 32'd1);

        // 3: wen+ren while full -> read only
        step(1'b1, 1'b1);
        chk("full_rw_count", 32'(count), 32'd7);
        chk("full_rw_full", 32'(full), 32'd0);
        @(posedge clk); #1;

        // 4: drain, then wen+ren while empty -> write only
        repeat (7) step(1'b0, 1'b1);
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_almost_empty", 32'(almost_empty), 32'd1);
        step(1'b1, 1'b1);
        chk("empty_rw_count", 32'(count), 32'd1);
        chk("empty_rw_empty", 32'(empty), 32'd0);
        @(posedge clk); #1;
        chk("empty_rw_no_rvalid", 32'(rvalid), 32'd0);
        step(1'b0, 1'b1);

        // 5: 20 interleaved write/read pairs across the pointer wrap
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0);
            chk("wrap_count_w", 32'(count), 32'd1);
            step(1'b0, 1'b1);
            chk("wrap_count_r", 32'(count), 32'd0);
        end
        @(posedge clk); #1;

        // 6: reset with count=5 and a read in flight plus a new read request
        repeat (6) step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        chk("pre_rst_count", 32'(count), 32'd5);
        chk("pre_rst_rvalid", 32'(rvalid), 32'd1);
        do_reset();
        ren = 1'b1;
        #1;
        chk("async_rst_count", 32'(count), 32'd0);
        chk("async_rst_rvalid", 32'(rvalid), 32'd0);
        chk("async_rst_mem_ren", 32'(mem_ren), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        ren = 1'b0;
        chk("post_rst_count", 32'(count), 32'd0);
        chk("post_rst_rvalid", 32'(rvalid), 32'd0);
        chk("post_rst_empty", 32'(empty), 32'd1);

`ifdef GENERIC_FIFO_ERR_FLAGS_EN
        chk("uf_reset", 32'(underflow), 32'd0);
        step(1'b0, 1'b1);
        chk("uf_set", 32'(underflow), 32'd1);
        @(posedge clk); #1;
        chk("uf_sticky", 32'(underflow), 32'd1);
        err_clr = 1'b1;
        step(1'b0, 1'b1);
        chk("uf_set_wins", 32'(underflow), 32'd1);
        step(1'b0, 1'b0);
        err_clr = 1'b0;
        chk("uf_cleared", 32'(underflow), 32'd0);
        repeat (8) step(1'b1, 1'b0);
        chk("of_clear_before", 32'(overflow), 32'd0);
        step(1'b1, 1'b0);
        chk("of_set", 32'(overflow), 32'd1);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        chk("of_cleared", 32'(overflow), 32'd0);
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("wa_q_drained", 32'(wa_q.size()), 32'd0);
        chk("ra_q_drained", 32'(ra_q.size()), 32'd0);
        chk("rd_q_drained", 32'(rd_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
